// File: rtl/seg_scan_driver.sv
// Purpose : six-digit seven-segment scan driver with per-slot blanking, 4-bit PWM dimming and frame-synchronous input snapshot.
// Latency : all outputs registered; pins reflect the state/cnt/idx computed on the same clock edge.
// Backpr. : none; the display inputs are sampled, never stalled, and only captured at frame boundaries.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          asynchronous active-high reset; blanks the outputs immediately
//   en           scan enable; low blanks the display and parks the FSM in IDLE
//   disp0..disp5 active-low segment patterns (bit7 = decimal point); disp0 is the rightmost digit
//   brightness   PWM duty, 0 = off, 15 = fully on; sampled live every cycle
//   lamp_test    forces every segment on during DRIVE (only when SEG_SCAN_LAMP_TEST_EN is defined)
//   seg_n        shared active-low segment bus
//   dig_en_n     active-low digit enables, at most one bit low; bit i selects digit i
//   frame_tick   one-cycle pulse after the edge where the scan wraps from digit 5 to digit 0
//
// Build option: define SEG_SCAN_LAMP_TEST_EN to add the lamp_test port and its override.

module seg_scan_driver #(
   parameter int CLK_DIV      = 50000,  // clock cycles per digit slot, >= 2
   parameter int BLANK_CYCLES = 16      // blanked cycles at slot start, 1 <= BLANK_CYCLES < CLK_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] disp0,
   input  logic [7:0] disp1,
   input  logic [7:0] disp2,
   input  logic [7:0] disp3,
   input  logic [7:0] disp4,
   input  logic [7:0] disp5,
   input  logic [3:0] brightness,
`ifdef SEG_SCAN_LAMP_TEST_EN
   input  logic       lamp_test,
`endif
   output logic [7:0] seg_n,
   output logic [5:0] dig_en_n,
   output logic       frame_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [2:0]      idx, idx_nx;
   logic [3:0]      pwm, pwm_nx;
   logic            capture;
   logic            tick_nx;

   // Frame snapshot of the six patterns; entry i feeds digit i.
   logic [5:0][7:0] shadow;

   logic [7:0]      pattern;
   logic [7:0]      seg_nx;
   logic [5:0]      dig_nx;
   logic [5:0]      dig_sel_n;
   logic            pwm_on;
   logic            force_on;

   // ------------------------------------------------------------------
   // Next-state logic: slot counter, digit index, PWM phase, capture.
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      pwm_nx   = pwm;
      capture  = 1'b0;
      tick_nx  = 1'b0;

      if (!en) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         idx_nx   = 3'd0;
         pwm_nx   = 4'd0;
      end else if (state == IDLE) begin
         // Scan always restarts on digit 0 with a fresh snapshot; no frame_tick here.
         state_nx = BLANK;
         cnt_nx   = '0;
         idx_nx   = 3'd0;
         pwm_nx   = 4'd0;
         capture  = 1'b1;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt_nx = '0;
            if (idx == 3'd5) begin
               idx_nx  = 3'd0;
               capture = 1'b1;
               tick_nx = 1'b1;
            end else begin
               idx_nx = idx + 3'd1;
            end
         end else begin
            cnt_nx = cnt + 1'b1;
         end

         // The phase is decided from the counter value the slot is about to
         // hold, so the registered pins line up with cnt without an extra stage.
         if (cnt_nx < BLANK_END) begin
            state_nx = BLANK;
            pwm_nx   = 4'd0;
         end else begin
            state_nx = DRIVE;
            // First drive cycle of a slot starts the PWM phase at 0.
            pwm_nx   = (state == DRIVE) ? pwm + 4'd1 : 4'd0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Output decode for the upcoming cycle.
   // ------------------------------------------------------------------
   always_comb begin
      pattern = 8'hFF;
      case (idx_nx)
         3'd0:    pattern = shadow[0];
         3'd1:    pattern = shadow[1];
         3'd2:    pattern = shadow[2];
         3'd3:    pattern = shadow[3];
         3'd4:    pattern = shadow[4];
         3'd5:    pattern = shadow[5];
         default: pattern = 8'hFF;
      endcase
   end

   always_comb begin
      dig_sel_n = ~(6'b00_0001 << idx_nx);
      pwm_on    = (brightness == 4'hF) || (pwm_nx < brightness);
`ifdef SEG_SCAN_LAMP_TEST_EN
      force_on  = lamp_test;
`else
      force_on  = 1'b0;
`endif
   end

   always_comb begin
      seg_nx = 8'hFF;
      dig_nx = 6'h3F;
      // A capture edge always lands on cnt 0, which is BLANK, so reading the
      // current shadow here never misses a just-captured pattern.
      if (state_nx == DRIVE) begin
         if (force_on) begin
            seg_nx = 8'h00;
            dig_nx = dig_sel_n;
         end else begin
            seg_nx = pattern;
            if (pwm_on) begin
               dig_nx = dig_sel_n;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // State and output registers.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= 3'd0;
         pwm        <= 4'd0;
         shadow     <= {6{8'hFF}};
         seg_n      <= 8'hFF;
         dig_en_n   <= 6'h3F;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         idx        <= idx_nx;
         pwm        <= pwm_nx;
         seg_n      <= seg_nx;
         dig_en_n   <= dig_nx;
         frame_tick <= tick_nx;
         if (capture) begin
            shadow <= {disp5, disp4, disp3, disp2, disp1, disp0};
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with CLK_DIV=8, BLANK_CYCLES=2.
// A cycle-position model predicts every output cycle; predictions are queued
// when inputs are driven and popped once the DUT's registered outputs settle.

module tb_seg_scan_driver;

   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = 6 * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] disp0 = 8'hFF, disp1 = 8'hFF, disp2 = 8'hFF;
   logic [7:0] disp3 = 8'hFF, disp4 = 8'hFF, disp5 = 8'hFF;
   logic [3:0] brightness = 4'd0;
   logic       lamp_test = 1'b0;
   logic [7:0] seg_n;
   logic [5:0] dig_en_n;
   logic       frame_tick;

   seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .disp0      (disp0),
      .disp1      (disp1),
      .disp2      (disp2),
      .disp3      (disp3),
      .disp4      (disp4),
      .disp5      (disp5),
      .brightness (brightness),
`ifdef SEG_SCAN_LAMP_TEST_EN
      .lamp_test  (lamp_test),
`endif
      .seg_n      (seg_n),
      .dig_en_n   (dig_en_n),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] seg;
      logic [5:0] dig;
      logic       ft;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Model state: whether scanning, cycles since the enabling edge, snapshot.
   bit         m_active = 1'b0;
   int         m_t      = 0;
   logic [7:0] m_shadow [6];

   // Predict the outputs that the next rising edge will produce from the
   // inputs currently driven.
   task automatic model_push();
      exp_t e;
      int   slot;
      int   pos;
      e.seg = 8'hFF;
      e.dig = 6'h3F;
      e.ft  = 1'b0;
      if (!en) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_t      = 0;
         m_shadow = '{disp0, disp1, disp2, disp3, disp4, disp5};
      end else begin
         m_t  = m_t + 1;
         slot = (m_t / CLK_DIV) % 6;
         pos  = m_t % CLK_DIV;
         if (m_t % FRAME == 0) begin
            e.ft     = 1'b1;
            m_shadow = '{disp0, disp1, disp2, disp3, disp4, disp5};
         end
         if (pos >= BLANK) begin
            e.seg = m_shadow[slot];
            if (brightness == 4'd15 || (pos - BLANK) < int'(brightness))
               e.dig = 6'h3F ^ (6'b1 << slot);
`ifdef SEG_SCAN_LAMP_TEST_EN
            if (lamp_test) begin
               e.seg = 8'h00;
               e.dig = 6'h3F ^ (6'b1 << slot);
            end
`endif
         end
      end
      sb.push_back(e);
   endtask

   function automatic int cur_slot();
      return (m_t / CLK_DIV) % 6;
   endfunction

   function automatic int cur_pos();
      return m_t % CLK_DIV;
   endfunction

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({seg_n, dig_en_n, frame_tick} !== {8'hFF, 6'h3F, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got seg_n=%h dig_en_n=%h frame_tick=%b exp FF 3F 0",
                  seg_n, dig_en_n, frame_tick);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL reset_en_low cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
   endtask

   task automatic test_full_brightness();
      exp_t e;
      int   ticks = 0;
      disp0 = 8'hC0; disp1 = 8'hF9; disp2 = 8'hA4;
      disp3 = 8'hB0; disp4 = 8'h99; disp5 = 8'h92;
      brightness = 4'd15;
      en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         if (frame_tick === 1'b1) ticks++;
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL full_bright cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
      // Enable edge is cycle 0; wraps land on cycles 48 and 96.
      checks++;
      if (ticks !== 2) begin
         failures++;
         $display("FAIL frame_tick_count got %0d exp 2", ticks);
      end
   endtask

   task automatic test_pwm();
      exp_t e;
      brightness = 4'd3;
      for (int i = 0; i < 2 * FRAME; i++) begin
         if (i == FRAME) brightness = 4'd0;
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL pwm br=%0d cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     brightness, i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
   endtask

   task automatic test_shadow();
      exp_t e;
      bit   changed = 1'b0;
      brightness = 4'd15;
      for (int i = 0; i < 2 * FRAME + 10; i++) begin
         if (!changed && m_active && cur_slot() == 4) begin
            disp2   = 8'h80;
            changed = 1'b1;
         end
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL shadow cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
   endtask

   task automatic test_en_drop();
      exp_t e;
      bit   dropped = 1'b0;
      int   off = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (!dropped && m_active && cur_slot() == 3 && cur_pos() == 4) begin
            en      = 1'b0;
            dropped = 1'b1;
            disp0 = 8'h11; disp1 = 8'h22; disp2 = 8'h33;
            disp3 = 8'h44; disp4 = 8'h55; disp5 = 8'h66;
         end else if (dropped && !en) begin
            off++;
            if (off == 5) en = 1'b1;
         end
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL en_drop cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
      checks++;
      if (!dropped || en !== 1'b1) begin
         failures++;
         $display("FAIL en_drop_sequence got dropped=%b en=%b exp 1 1", dropped, en);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      int   guard = 0;
      while (!(m_active && cur_pos() >= BLANK + 1) && guard < 2 * CLK_DIV) begin
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         guard++;
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL pre_reset cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     guard, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({seg_n, dig_en_n, frame_tick} !== {8'hFF, 6'h3F, 1'b0}) begin
         failures++;
         $display("FAIL async_reset got %h/%h/%b exp FF/3F/0", seg_n, dig_en_n, frame_tick);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      m_active = 1'b0;
      for (int i = 0; i < FRAME + 4; i++) begin
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL post_reset cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
   endtask

`ifdef SEG_SCAN_LAMP_TEST_EN
   task automatic test_lamp();
      exp_t e;
      lamp_test  = 1'b1;
      brightness = 4'd0;
      for (int i = 0; i < FRAME + 8; i++) begin
         model_push();
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if ({seg_n, dig_en_n, frame_tick} !== e) begin
            failures++;
            $display("FAIL lamp cyc=%0d got %h/%h/%b exp %h/%h/%b",
                     i, seg_n, dig_en_n, frame_tick, e.seg, e.dig, e.ft);
         end
      end
      lamp_test = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_full_brightness();
      test_pwm();
      test_shadow();
      test_en_drop();
      test_async_reset();
`ifdef SEG_SCAN_LAMP_TEST_EN
      test_lamp();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog run did not complete checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scanning driver for the six-digit seven-segment display. It consumes the six 8-bit digit patterns produced by the display multiplexer and drives them onto one shared, active-low segment bus with six active-low digit enables. One digit is lit per slot. A blanking gap at each slot start prevents ghosting, and a 4-bit PWM sets brightness. Input patterns are snapshotted once per frame so a mid-frame change on the multiplexer never tears the display.

## Interface
- CLK_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16: blanked cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < CLK_DIV.
- clk  input  1  system clock; all logic rises on posedge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low blanks the display and holds the FSM in IDLE.
- disp0..disp5  input  8 each  digit patterns, active-low segments, bit7 = decimal point; disp0 is the rightmost digit.
- brightness  input  4  PWM duty: 0 = off, 15 = fully on.
- lamp_test  input  1  present only with SEG_SCAN_LAMP_TEST_EN.
- seg_n  output  8  shared segment bus, active-low.
- dig_en_n  output  6  digit enables, active-low, one-hot-low when driving; bit i selects digit i.
- frame_tick  output  1  one-cycle pulse at the end of each full six-slot frame.

## Operation
- FSM states:
  - IDLE: outputs blanked.
  - BLANK: slot active, cnt < BLANK_CYCLES.
  - DRIVE: cnt ≥ BLANK_CYCLES.
- Slot counter cnt: width $clog2(CLK_DIV), counts 0..CLK_DIV-1, then wraps to 0 and advances idx (0..5). idx wraps 5→0.
- IDLE → BLANK (idx=0, cnt=0) on the first clock with en=1.
- Any state → IDLE on the first clock with en=0. cnt, idx and pwm are cleared.
- Shadow capture: all six inputs are latched into shadow registers on the IDLE→BLANK edge and on every idx 5→0 edge. Displayed data comes only from the shadow registers.
- BLANK: seg_n=8'hFF, dig_en_n=6'h3F.
- DRIVE: seg_n = shadow[idx]. The 4-bit pwm counter increments every DRIVE cycle (wraps 15→0) and resets to 0 at each slot start.
  - dig_en_n[idx]=0 when brightness==15 or pwm < brightness; otherwise 6'h3F.
  - All other dig_en_n bits are 1.
- brightness is sampled live, not shadowed.
- frame_tick asserts for the one cycle following the edge on which idx goes 5→0. It is not asserted on IDLE→BLANK.

## Timing
- Reset values: seg_n=8'hFF, dig_en_n=6'h3F, frame_tick=0, state IDLE, cnt=0, idx=0, pwm=0, shadows=8'hFF.
- All outputs are registered. Pins reflect the state/cnt/idx computed on the same clock edge, so there is no extra pipeline stage.
- Frame period is 6×CLK_DIV cycles. Per slot: BLANK_CYCLES blanked cycles, then CLK_DIV−BLANK_CYCLES drive cycles.
- Reset asserted mid-slot blanks the outputs immediately (asynchronously). After release, the FSM resumes from IDLE.
- en deassert mid-slot: outputs blanked on the next edge. Re-enable restarts at idx 0 with a fresh shadow capture.
- en=1 with brightness=0: dig_en_n stays 6'h3F throughout, and the frame timing and frame_tick continue.
- Input changes during a frame have no visible effect until the next capture edge.

## Configuration
- SEG_SCAN_LAMP_TEST_EN defined:
  - The lamp_test port exists.
  - While lamp_test=1, DRIVE forces seg_n=8'h00 and enables dig_en_n[idx] regardless of brightness.
  - BLANK is unchanged, and shadow capture continues.
- Not defined: the lamp_test port and its logic are absent; behaviour is exactly as described above.

## Test plan
Bench parameters: CLK_DIV=8, BLANK_CYCLES=2.
- Reset, en=0 for 20 cycles → seg_n=8'hFF, dig_en_n=6'h3F, frame_tick=0 throughout.
- disp0..5 = 8'hC0, F9, A4, B0, 99, 92; brightness=15; en=1 → each slot shows 2 blank cycles, then 6 cycles with dig_en_n low on bit idx and seg_n = the matching pattern. frame_tick pulses once every 48 cycles.
- brightness=3, slot drive of 6 cycles → dig_en_n[idx] low for drive cycles 0–2 (pwm 0,1,2) and high for cycles 3–5. brightness=0 → never low.
- Change disp2 to 8'h80 during slot 4 → slot 2 of the current frame is unaffected; slot 2 of the next frame shows 8'h80.
- Drop en in the DRIVE portion of slot 3, re-raise 5 cycles later → blanked on the next edge; scan restarts at idx 0 with 2 blank cycles and freshly captured data.
- (SEG_SCAN_LAMP_TEST_EN) lamp_test=1, brightness=0 → in every DRIVE cycle seg_n=8'h00 and dig_en_n[idx]=0; BLANK cycles are still 8'hFF / 6'h3F.
